// File: rtl/btb_update_ctrl.sv
// BTB write-bus generator: classifies WB-stage branch resolutions and queues BTB writes.
// Optional macro BTB_NT_INVALIDATE_EN: not-taken BTB hits enqueue an invalidating write.
module btb_update_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br0_valid,
    input  logic [31:0] br0_pc,
    input  logic        br0_taken,
    input  logic [31:0] br0_target,
    input  logic        br0_pred_hit,
    input  logic [31:0] br0_pred_pc,
    input  logic        br1_valid,
    input  logic [31:0] br1_pc,
    input  logic        br1_taken,
    input  logic [31:0] br1_target,
    input  logic        br1_pred_hit,
    input  logic [31:0] br1_pred_pc,
    output logic [62:0] w_obus,
    output logic [15:0] drop_cnt,
    output logic        fifo_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        wvalid;
        logic [6:0]  waddr;
        logic [21:0] wtag;
        logic [31:0] wpc;
    } btb_wr_t;

    function automatic logic needs_update(input logic taken, input logic hit,
                                          input logic [31:0] target, input logic [31:0] pred_pc);
        logic install_or_retarget;
        install_or_retarget = taken && (!hit || (pred_pc != target));
`ifdef BTB_NT_INVALIDATE_EN
        return install_or_retarget || (!taken && hit);
`else
        return install_or_retarget;
`endif
    endfunction

    // A not-taken request only exists as an invalidate, so its payload clears wvalid and wpc.
    function automatic btb_wr_t make_payload(input logic [31:0] pc, input logic taken,
                                             input logic [31:0] target);
        btb_wr_t p;
        p.wvalid = taken;
        p.waddr  = pc[9:3];
        p.wtag   = pc[31:10];
        p.wpc    = taken ? target : 32'h0;
        return p;
    endfunction

    btb_wr_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nxt, free_cnt;
    logic               upd0, upd1, push0, pop;
    logic [1:0]         n_req, n_push, n_drop;
    btb_wr_t            req_a, req_b, head;
    logic [16:0]        drop_sum;
    logic               unused_pc_lsbs;

    assign unused_pc_lsbs = ^{br0_pc[2:0], br1_pc[2:0]};

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        upd0   = br0_valid && needs_update(br0_taken, br0_pred_hit, br0_target, br0_pred_pc);
        upd1   = br1_valid && needs_update(br1_taken, br1_pred_hit, br1_target, br1_pred_pc);
        // Slot 1 is younger and would overwrite slot 0 at the same BTB index.
        push0  = upd0 && !(upd1 && (br0_pc[9:3] == br1_pc[9:3]));
        req_a  = push0 ? make_payload(br0_pc, br0_taken, br0_target)
                       : make_payload(br1_pc, br1_taken, br1_target);
        req_b  = make_payload(br1_pc, br1_taken, br1_target);
        n_req  = 2'(push0) + 2'(upd1);
        pop    = (count != '0);
        // Free space counts the entry popped this same cycle.
        free_cnt = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
        n_push = (CNT_W'(n_req) > free_cnt) ? free_cnt[1:0] : n_req;
        n_drop = n_req - n_push;
        count_nxt = count - CNT_W'(pop) + CNT_W'(n_push);
        drop_sum  = {1'b0, drop_cnt} + 17'(n_drop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PTR_W'(n_push);
            rd_ptr   <= rd_ptr + PTR_W'(pop);
            count    <= count_nxt;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // NOTE: queue storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (n_push != 2'd0) mem[wr_ptr] <= req_a;
            if (n_push == 2'd2) mem[wr_ptr + PTR_W'(1)] <= req_b;
        end
    end

    assign head      = mem[rd_ptr];
    assign w_obus    = pop ? {1'b1, head} : 63'h0;
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl (FIFO_DEPTH=4), macro-aware for BTB_NT_INVALIDATE_EN.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br0_valid, br0_taken, br0_pred_hit;
    logic [31:0] br0_pc, br0_target, br0_pred_pc;
    logic        br1_valid, br1_taken, br1_pred_hit;
    logic [31:0] br1_pc, br1_target, br1_pred_pc;
    logic [62:0] w_obus;
    logic [15:0] drop_cnt;
    logic        fifo_full;

    int tests = 0;
    int fails = 0;

    btb_update_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .br0_valid(br0_valid), .br0_pc(br0_pc), .br0_taken(br0_taken),
        .br0_target(br0_target), .br0_pred_hit(br0_pred_hit), .br0_pred_pc(br0_pred_pc),
        .br1_valid(br1_valid), .br1_pc(br1_pc), .br1_taken(br1_taken),
        .br1_target(br1_target), .br1_pred_hit(br1_pred_hit), .br1_pred_pc(br1_pred_pc),
        .w_obus(w_obus), .drop_cnt(drop_cnt), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [62:0] obs, input logic [62:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected bus word for a write: {we=1, wvalid, pc[9:3], pc[31:10], wpc}.
    function automatic logic [62:0] wr(input logic v, input logic [31:0] pc, input logic [31:0] wpc);
        return {1'b1, v, pc[9:3], pc[31:10], wpc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic hit, input logic [31:0] pp);
        br0_valid = v; br0_pc = pc; br0_taken = tk; br0_target = tgt; br0_pred_hit = hit; br0_pred_pc = pp;
    endtask

    task automatic set1(input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic hit, input logic [31:0] pp);
        br1_valid = v; br1_pc = pc; br1_taken = tk; br1_target = tgt; br1_pred_hit = hit; br1_pred_pc = pp;
    endtask

    task automatic idle();
        set0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        set1(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Install pair at two distinct indices; target = pc + 0x1000.
    task automatic pair(input logic [31:0] pc_a, input logic [31:0] pc_b);
        set0(1'b1, pc_a, 1'b1, pc_a + 32'h1000, 1'b0, 32'h0);
        set1(1'b1, pc_b, 1'b1, pc_b + 32'h1000, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        check("reset_wobus", w_obus, 63'h0);
        check("reset_drop", 63'(drop_cnt), 63'h0);
        check("reset_full", 63'(fifo_full), 63'h0);
        rst_n = 1'b1;

        // Single install appears next cycle, queue empty the cycle after.
        set0(1'b1, 32'h1C000048, 1'b1, 32'h1C000100, 1'b0, 32'h0);
        tick();
        idle();
        check("install", w_obus, {1'b1, 1'b1, 7'h09, 22'h070000, 32'h1C000100});
        tick();
        check("install_drained", w_obus, 63'h0);

        // Correct prediction: no write.
        set0(1'b1, 32'h1C000048, 1'b1, 32'h1C000100, 1'b1, 32'h1C000100);
        tick();
        idle();
        check("correct_pred", w_obus, 63'h0);
        check("correct_pred_drop", 63'(drop_cnt), 63'h0);

        // Retarget from slot 1 alone.
        set1(1'b1, 32'h00001230, 1'b1, 32'h00002000, 1'b1, 32'h00003000);
        tick();
        idle();
        check("retarget", w_obus, {1'b1, 1'b1, 7'h46, 22'h000004, 32'h00002000});
        tick();
        check("retarget_drained", w_obus, 63'h0);

        // Same-index coalesce: only slot 1 written.
        set0(1'b1, 32'h1C000048, 1'b1, 32'h1C000100, 1'b0, 32'h0);
        set1(1'b1, 32'h1C000448, 1'b1, 32'h1C000200, 1'b0, 32'h0);
        tick();
        idle();
        check("coalesce", w_obus, {1'b1, 1'b1, 7'h09, 22'h070001, 32'h1C000200});
        tick();
        check("coalesce_single", w_obus, 63'h0);

        // Not-taken hit.
        set0(1'b1, 32'h00000010, 1'b0, 32'h00000040, 1'b1, 32'h00000040);
        tick();
        idle();
`ifdef BTB_NT_INVALIDATE_EN
        check("nt_hit", w_obus, {1'b1, 1'b0, 7'h02, 22'h000000, 32'h0});
`else
        check("nt_hit", w_obus, 63'h0);
`endif
        tick();
        check("nt_hit_after", w_obus, 63'h0);

        // Slot 0 install, slot 1 not-taken hit at the same index.
        set0(1'b1, 32'h00000010, 1'b1, 32'h00000100, 1'b0, 32'h0);
        set1(1'b1, 32'h00000410, 1'b0, 32'h00000500, 1'b1, 32'h00000500);
        tick();
        idle();
`ifdef BTB_NT_INVALIDATE_EN
        check("mixed_idx", w_obus, {1'b1, 1'b0, 7'h02, 22'h000001, 32'h0});
`else
        check("mixed_idx", w_obus, {1'b1, 1'b1, 7'h02, 22'h000000, 32'h00000100});
`endif
        tick();
        check("mixed_idx_after", w_obus, 63'h0);

        // Overflow: four install pairs back to back; the last slot-1 request is dropped.
        pair(32'h100, 32'h108);
        tick();
        check("ovf_p1s0", w_obus, wr(1'b1, 32'h100, 32'h1100));
        pair(32'h110, 32'h118);
        tick();
        check("ovf_p1s1", w_obus, wr(1'b1, 32'h108, 32'h1108));
        check("ovf_not_full", 63'(fifo_full), 63'h0);
        pair(32'h120, 32'h128);
        tick();
        check("ovf_p2s0", w_obus, wr(1'b1, 32'h110, 32'h1110));
        check("ovf_full", 63'(fifo_full), 63'h1);
        check("ovf_no_drop_yet", 63'(drop_cnt), 63'h0);
        pair(32'h130, 32'h138);
        tick();
        idle();
        check("ovf_p2s1", w_obus, wr(1'b1, 32'h118, 32'h1118));
        check("ovf_drop", 63'(drop_cnt), 63'h1);
        check("ovf_still_full", 63'(fifo_full), 63'h1);
        tick();
        check("ovf_p3s0", w_obus, wr(1'b1, 32'h120, 32'h1120));
        check("ovf_full_clear", 63'(fifo_full), 63'h0);
        tick();
        check("ovf_p3s1", w_obus, wr(1'b1, 32'h128, 32'h1128));
        tick();
        check("ovf_p4s0", w_obus, wr(1'b1, 32'h130, 32'h1130));
        tick();
        check("ovf_empty", w_obus, 63'h0);
        check("ovf_drop_hold", 63'(drop_cnt), 63'h1);

        // Reset with three entries queued.
        pair(32'h200, 32'h208);
        tick();
        pair(32'h210, 32'h218);
        tick();
        idle();
        check("pre_reset_head", w_obus, wr(1'b1, 32'h208, 32'h1208));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_wobus", w_obus, 63'h0);
        check("rst_mid_drop", 63'(drop_cnt), 63'h0);
        check("rst_mid_full", 63'(fifo_full), 63'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_stale", w_obus, 63'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
